// File: rtl/avalon_sram_frame_reader.sv
// avalon_sram_frame_reader: streams a frame buffer from SRAM into a prefetch FIFO and arbitrates host writes
// Optional feature: define FRAME_READER_UNDERFLOW_EN to build the sticky underflow detector.
module avalon_sram_frame_reader #(
    parameter int AVN_AW      = 18,
    parameter int AVN_DW      = 16,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_WORDS = 76800,
    parameter int FIFO_DEPTH  = 16,
    parameter int LOW_WATER   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    output logic                  pix_valid,
    output logic [AVN_DW-1:0]     pix_data,
    input  logic                  pix_ready,
    input  logic                  host_write,
    input  logic [AVN_AW-1:0]     host_address,
    input  logic [AVN_DW-1:0]     host_writedata,
    input  logic [AVN_DW/8-1:0]   host_byteenable,
    output logic                  host_ready,
    output logic                  avn_read,
    output logic                  avn_write,
    output logic [AVN_AW-1:0]     avn_address,
    output logic [AVN_DW-1:0]     avn_writedata,
    output logic [AVN_DW/8-1:0]   avn_byteenable,
    input  logic [AVN_DW-1:0]     avn_readdata,
    output logic                  underflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int WW = $clog2(FRAME_WORDS + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [AVN_AW-1:0] addr_q, addr_d;
    logic [WW-1:0] words_q, words_d;
    logic inflight_q, inflight_d;
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0] cnt_q, cnt_d;
    logic [AVN_DW-1:0] mem_q [FIFO_DEPTH];
    logic [PW+1:0] level;
    logic credit, low, read_go, write_go, push, pop;
    assign pix_valid      = cnt_q != '0;
    assign pix_data       = mem_q[rd_q];
    assign avn_read       = read_go;
    assign avn_write      = write_go;
    assign host_ready     = write_go;
    assign avn_address    = write_go ? host_address : addr_q;
    assign avn_writedata  = write_go ? host_writedata : '0;
    assign avn_byteenable = write_go ? host_byteenable : '1;
    // Arbitration: starving FIFO beats host, host beats opportunistic prefetch; credit counts the in-flight word
    always_comb begin
        level    = {1'b0, cnt_q} + (PW+2)'(inflight_q);
        credit   = level < (PW+2)'(FIFO_DEPTH);
        low      = level < (PW+2)'(LOW_WATER);
        read_go  = !reset && state_q == RUN && !frame_start && credit && (low || !host_write);
        write_go = !reset && host_write && !read_go;
        push     = inflight_q && !frame_start;
        pop      = pix_valid && pix_ready;
    end
    // Next state: frame_start flushes and restarts; otherwise advance fetch pointer and FIFO
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        words_d    = words_q;
        inflight_d = read_go;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        if (frame_start) begin
            state_d = RUN;
            addr_d  = AVN_AW'(FRAME_BASE);
            words_d = '0;
            wr_d    = '0;
            rd_d    = '0;
            cnt_d   = '0;
        end else begin
            if (read_go) begin
                addr_d  = addr_q + AVN_AW'(1);
                words_d = words_q + WW'(1);
                state_d = (words_q == WW'(FRAME_WORDS - 1)) ? DONE : RUN;
            end
            wr_d  = wr_q + PW'(push);
            rd_d  = rd_q + PW'(pop);
            cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    // Control registers; reset drops any in-flight read
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_q     <= AVN_AW'(FRAME_BASE);
            words_q    <= '0;
            inflight_q <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            words_q    <= words_d;
            inflight_q <= inflight_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
        end
    end
    // FIFO storage captures the word returned one cycle after the read strobe
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= avn_readdata;
    end
`ifdef FRAME_READER_UNDERFLOW_EN
    logic uf_q, uf_d;
    // Sticky flag: consumer wanted a pixel while the frame still had words outstanding
    always_comb begin
        uf_d = frame_start ? 1'b0
             : uf_q | (pix_ready && !pix_valid && (state_q == RUN || (state_q == DONE && inflight_q)));
    end
    // Underflow register
    always_ff @(posedge clk) begin
        if (reset) uf_q <= 1'b0;
        else uf_q <= uf_d;
    end
    assign underflow = uf_q;
`else
    assign underflow = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_sram_frame_reader.sv
// tb_avalon_sram_frame_reader: directed plus randomized checks against a queue-based reference model
module tb_avalon_sram_frame_reader;
    localparam int AW = 18, DW = 16, BASE = 100, FW = 40, DEPTH = 16, LW = 4;
`ifdef FRAME_READER_UNDERFLOW_EN
    localparam bit UF_EN = 1'b1;
`else
    localparam bit UF_EN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b1, frame_start = 1'b0, pix_ready = 1'b0, host_write = 1'b0;
    logic [AW-1:0] host_address = '0;
    logic [DW-1:0] host_writedata = '0, avn_readdata = '0;
    logic [1:0] host_byteenable = '0;
    logic pix_valid, host_ready, avn_read, avn_write, underflow;
    logic [DW-1:0] pix_data, avn_writedata;
    logic [AW-1:0] avn_address;
    logic [1:0] avn_byteenable;

    always #5 clk = ~clk;

    avalon_sram_frame_reader #(.AVN_AW(AW), .AVN_DW(DW), .FRAME_BASE(BASE), .FRAME_WORDS(FW),
                               .FIFO_DEPTH(DEPTH), .LOW_WATER(LW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .host_write(host_write), .host_address(host_address),
        .host_writedata(host_writedata), .host_byteenable(host_byteenable), .host_ready(host_ready),
        .avn_read(avn_read), .avn_write(avn_write), .avn_address(avn_address),
        .avn_writedata(avn_writedata), .avn_byteenable(avn_byteenable), .avn_readdata(avn_readdata),
        .underflow(underflow));

    logic [DW-1:0] q[$];
    logic [DW-1:0] sram[int];
    logic [DW-1:0] pend;
    bit infl, run, uf, acc, last_rd;
    int reads, n_chk, n_fail, obs_reads, obs_writes, obs_pops;
    logic [AW-1:0] last_addr;

    function automatic logic [DW-1:0] mem_rd(int a);
        return sram.exists(a) ? sram[a] : DW'(a);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_host();
        host_address    = AW'(20000 + $urandom_range(0, 999));
        host_writedata  = DW'($urandom);
        host_byteenable = 2'($urandom_range(1, 3));
    endtask

    task automatic tick();
        bit er, ew, pop;
        int lvl;
        logic [DW-1:0] rv, old;
        @(negedge clk);
        lvl = q.size() + int'(infl);
        er = !reset && run && !frame_start && reads < FW && lvl < DEPTH && (lvl < LW || !host_write);
        ew = !reset && host_write && !er;
        chk("avn_read", 32'(avn_read), 32'(er));
        chk("avn_write", 32'(avn_write), 32'(ew));
        chk("host_ready", 32'(host_ready), 32'(ew));
        chk("pix_valid", 32'(pix_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("pix_data", 32'(pix_data), 32'(q[0]));
        if (er) begin
            chk("rd_addr", 32'(avn_address), 32'(BASE + reads));
            chk("rd_be", 32'(avn_byteenable), 32'h3);
        end
        if (ew) begin
            chk("wr_addr", 32'(avn_address), 32'(host_address));
            chk("wr_data", 32'(avn_writedata), 32'(host_writedata));
            chk("wr_be", 32'(avn_byteenable), 32'(host_byteenable));
        end
        chk("underflow", 32'(underflow), 32'(uf));
        obs_reads += int'(avn_read);
        obs_writes += int'(avn_write);
        obs_pops += int'(pix_valid && pix_ready);
        acc = ew;
        last_rd = avn_read;
        last_addr = avn_address;
        rv = er ? mem_rd(BASE + reads) : DW'($urandom);
        pop = q.size() != 0 && pix_ready;
        if (reset) begin
            q.delete(); infl = 0; run = 0; reads = 0; uf = 0;
        end else if (frame_start) begin
            q.delete(); infl = 0; run = 1; reads = 0; uf = 0;
        end else begin
            if (UF_EN && pix_ready && q.size() == 0 && run && (reads < FW || infl)) uf = 1;
            if (pop) void'(q.pop_front());
            if (infl) q.push_back(pend);
            if (er) pend = rv;
            infl = er;
            reads += int'(er);
        end
        if (ew) begin
            old = mem_rd(int'(host_address));
            sram[int'(host_address)] = {host_byteenable[1] ? host_writedata[15:8] : old[15:8],
                                        host_byteenable[0] ? host_writedata[7:0] : old[7:0]};
        end
        @(posedge clk);
        #1;
        avn_readdata = rv;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_pix_valid", 32'(pix_valid), 32'h0);
        chk("rst_avn_read", 32'(avn_read), 32'h0);
        chk("rst_underflow", 32'(underflow), 32'h0);
        // full frame drained with consumer always ready
        frame_start = 1'b1; pix_ready = 1'b1; obs_reads = 0; obs_pops = 0;
        tick();
        frame_start = 1'b0;
        repeat (80) tick();
        chk("frame_reads", 32'(obs_reads), 32'(FW));
        chk("frame_pops", 32'(obs_pops), 32'(FW));
        // credit limit with stalled consumer
        frame_start = 1'b1; pix_ready = 1'b0; obs_reads = 0;
        tick();
        frame_start = 1'b0;
        repeat (40) tick();
        chk("credit_reads", 32'(obs_reads), 32'(DEPTH));
        obs_reads = 0; pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        repeat (5) tick();
        chk("credit_one_more", 32'(obs_reads), 32'h1);
        // host write accepted immediately with FIFO above low water
        new_host(); host_write = 1'b1; obs_writes = 0;
        tick();
        host_write = 1'b0;
        chk("host_accept_full", 32'(obs_writes), 32'h1);
        tick();
        // host write deferred while FIFO below low water
        frame_start = 1'b1; obs_reads = 0;
        tick();
        frame_start = 1'b0; new_host(); host_write = 1'b1; acc = 0;
        for (int i = 0; i < 20 && !acc; i++) tick();
        host_write = 1'b0;
        chk("low_water_accept", 32'(acc), 32'h1);
        chk("reads_before_write", 32'(obs_reads), 32'(LW));
        // frame_start the cycle after a read drops the returning word
        frame_start = 1'b1; pix_ready = 1'b1;
        tick();
        frame_start = 1'b0; last_rd = 0;
        for (int i = 0; i < 10 && !last_rd; i++) tick();
        chk("read_seen", 32'(last_rd), 32'h1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("flush_empty", 32'(pix_valid), 32'h0);
        chk("restart_read", 32'(last_rd), 32'h1);
        chk("restart_addr", 32'(last_addr), 32'(BASE));
        // underflow is sticky until frame_start
        repeat (3) tick();
        chk("underflow_set", 32'(underflow), 32'(UF_EN));
        pix_ready = 1'b0;
        repeat (30) tick();
        chk("underflow_sticky", 32'(underflow), 32'(UF_EN));
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("underflow_clear", 32'(underflow), 32'h0);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            pix_ready = $urandom_range(0, 3) != 0;
            if (!host_write || acc) begin
                host_write = $urandom_range(0, 2) == 0;
                new_host();
            end
            frame_start = $urandom_range(0, 99) == 0;
            reset = $urandom_range(0, 499) == 0;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
